// File: rtl/tx_arbiter.sv
// Two-requester packet arbiter in front of the UART transmitter: round-robin at packet
// granularity, packets locked until their last byte is sent, stall timeout forces release.
module tx_arbiter #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TW      = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       r0_valid,
  input  logic [7:0] r0_data,
  input  logic       r0_last,
  output logic       r0_ready,
  input  logic       r1_valid,
  input  logic [7:0] r1_data,
  input  logic       r1_last,
  output logic       r1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       abort
);

  typedef enum logic [1:0] {StIdle, StLoad, StStartWait, StBusy} state_e;

  localparam logic [TW-1:0] TimeoutCnt = TW'(TIMEOUT);

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic [1:0]      grant_q, grant_d;
  logic            rr_q, rr_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            abort_q, abort_d;
  logic            last_q, last_d;
  logic [TW-1:0]   cnt_q, cnt_d;

  logic            own_valid, own_last, load_ready, accept, pick;
  logic [7:0]      own_data;

  assign own_valid  = owner_q ? r1_valid : r0_valid;
  assign own_data   = owner_q ? r1_data  : r0_data;
  assign own_last   = owner_q ? r1_last  : r0_last;
  assign load_ready = (state_q == StLoad) && !tx_busy;
  assign accept     = load_ready && own_valid;
  // Contention goes to the round-robin pointer; otherwise to whoever is asking.
  assign pick       = (r0_valid && r1_valid) ? rr_q : r1_valid;

  assign r0_ready = load_ready && !owner_q;
  assign r1_ready = load_ready && owner_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant    = grant_q;
  assign abort    = abort_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    abort_d    = 1'b0;
    last_d     = last_q;
    cnt_d      = cnt_q;
    case (state_q)
      StIdle: begin
        if (r0_valid || r1_valid) begin
          owner_d = pick;
          grant_d = pick ? 2'b10 : 2'b01;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (accept) begin
          tx_data_d  = own_data;
          tx_start_d = 1'b1;
          last_d     = own_last;
          cnt_d      = '0;
          state_d    = StStartWait;
        end else if (!own_valid) begin
          // This cycle is the TIMEOUT-th stalled one: release the transmitter.
          if (cnt_q >= TimeoutCnt - 1'b1) begin
            cnt_d   = TimeoutCnt;
            abort_d = 1'b1;
            grant_d = 2'b00;
            rr_d    = ~owner_q;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StStartWait: begin
        if (tx_busy) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_d = 2'b00;
            rr_d    = ~owner_q;
            state_d = StIdle;
          end else begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      grant_q    <= 2'b00;
      rr_q       <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      abort_q    <= 1'b0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      abort_q    <= abort_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Shares the single serial transmitter between two byte-stream requesters: requester 0 is the mapper's frame stream, requester 1 is the event/message source (score and status text). Packets are atomic: once a requester is granted, it owns the transmitter until its `last` byte has been fully sent. Fairness between requesters is round-robin at packet granularity. A stall timeout recovers from a requester that stops mid-packet. The block sits between the game's output producers and the UART transmitter.

## Interface
- `TIMEOUT`, 1023: idle cycles tolerated mid-packet (owner `valid` low in LOAD) before forced release.
- `TW`, 10: timeout counter width; must satisfy 2^TW > TIMEOUT.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `r0_valid`  in  1  requester 0 has a byte.
- `r0_data`  in  8  requester 0 byte.
- `r0_last`  in  1  byte is the final byte of a packet.
- `r0_ready`  out  1  byte accepted this cycle (accepted when valid & ready).
- `r1_valid`, `r1_data`, `r1_last`, `r1_ready`: same as above, for requester 1.
- `tx_start`  out  1  one-cycle pulse: transmitter loads `tx_data`.
- `tx_data`  out  8  byte to transmit; registered.
- `tx_busy`  in  1  transmitter busy. Transmitter raises it the cycle after `tx_start` and holds it until the byte is done.
- `grant`  out  2  one-hot current owner; 00 when none.
- `abort`  out  1  one-cycle pulse when a packet is force-released by timeout.

## Operation
- States: IDLE, LOAD, START_WAIT, BUSY.
- IDLE, grant=00:
  - If exactly one `valid` is high, that requester becomes owner.
  - If both are high, the round-robin pointer `rr` decides; `rr` is 0 after reset, so requester 0 wins.
  - Owner set → `grant` updated → LOAD.
- LOAD:
  - `rX_ready` = (owner==X) & !tx_busy, combinational.
  - On accept:
    - `tx_data` <= data, `tx_start` <= 1, `last_q` <= last.
    - Timeout counter cleared.
    - → START_WAIT.
  - While the owner's `valid` is low, the timeout counter increments.
  - When the counter reaches TIMEOUT:
    - `abort` pulses, `grant` <= 00.
    - `rr` <= other requester.
    - → IDLE.
- START_WAIT: `tx_start` returns to 0. Wait for `tx_busy`=1, then → BUSY.
- BUSY: wait for `tx_busy`=0.
  - If `last_q`: `grant` <= 00, `rr` <= other requester, → IDLE.
  - Otherwise: → LOAD.
- The non-owner's `valid` is ignored, and its `ready` stays 0, for the whole packet.
- Owner dropping `valid` mid-packet is legal; the packet stays locked until `last` or timeout.
- `last` on the first byte is a legal one-byte packet.
- Timeout counter saturates at TIMEOUT; it is cleared on every accept and on entry to LOAD from IDLE.

## Timing
- Reset values: state IDLE, `grant`=00, `tx_start`=0, `tx_data`=8'h00, `abort`=0, `rr`=0, counter=0, both `ready`=0.
- Asserting `reset_n` low mid-packet clears everything immediately. A transmitter byte already in flight is not cancelled.
- Latencies:
  - `valid` rising in IDLE → `grant` set on the next edge.
  - `ready` can be high in the following cycle.
  - Accept → `tx_start` high on the next edge, for exactly 1 cycle.
- Per-byte minimum overhead: LOAD 1 + START_WAIT 1 + BUSY (transmitter time) + return to LOAD 1 cycle.
- Between packets: 1 IDLE cycle before the next grant.
- At most one `ready` is high in any cycle. `ready` is never high while `tx_busy`=1.
- `abort` and `tx_start` never pulse in the same cycle.

## Test plan
- Single packet: r0 sends 3 bytes 8'h41, 8'h42, 8'h43 (`last` on 8'h43), `tx_busy` modelled as 10 cycles.
  - Required: 3 `tx_start` pulses, `tx_data` in that order.
  - `grant` goes 01 → 00 one cycle after `tx_busy` falls for the third byte.
- Simultaneous request out of reset: both requesters valid with 2-byte packets.
  - Required: r0 packet completes first, then r1.
  - Repeat both: r0 is served first again, because `rr` flipped after r1's packet.
- Lock: r1 raises `valid` while r0 is mid-packet.
  - Required: `r1_ready` stays 0 and no r1 byte appears on `tx_data` until r0's `last` byte finishes.
- Timeout: r0 sends 1 byte (`last`=0), then holds `valid` low.
  - Required: `abort` pulses exactly TIMEOUT cycles after entering LOAD, then `grant`=00.
  - A pending r1 is granted next.
- Busy respect: hold `tx_busy`=1 while the owner is valid in LOAD.
  - Required: `ready`=0 and no `tx_start` until `tx_busy` drops.
- Reset mid-packet: pull `reset_n` low during BUSY.
  - Required: `grant`=00, `tx_start`=0, `tx_data`=00 immediately, state IDLE after release.
